// File: rtl/axi_lite_protocol_checker.sv
// axi_lite_protocol_checker: passive AXI4-Lite monitor with sticky error bits, pulse and first-error code
module axi_lite_protocol_checker #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT = 256,
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                awvalid,
  input  logic                awready,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [2:0]          awprot,
  input  logic                wvalid,
  input  logic                wready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                bvalid,
  input  logic                bready,
  input  logic [1:0]          bresp,
  input  logic                arvalid,
  input  logic                arready,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [2:0]          arprot,
  input  logic                rvalid,
  input  logic                rready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                err_clr,
  output logic [11:0]         err_status,
  output logic                err_pulse,
  output logic                err_any,
  output logic [3:0]          first_err_code,
  output logic [CNT_W-1:0]    wr_outstanding,
  output logic [CNT_W-1:0]    rd_outstanding
);
  localparam int TW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] MAXC = CNT_W'(MAX_OUTSTANDING);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
  localparam logic [TW-1:0] TM1 = TW'(TIMEOUT - 1);
  logic                hist_v;
  logic                p_awvalid, p_awready, p_wvalid, p_wready, p_bvalid, p_bready;
  logic                p_arvalid, p_arready, p_rvalid, p_rready;
  logic [ADDR_W-1:0]   p_awaddr, p_araddr;
  logic [2:0]          p_awprot, p_arprot;
  logic [DATA_W-1:0]   p_wdata, p_rdata;
  logic [DATA_W/8-1:0] p_wstrb;
  logic [1:0]          p_bresp, p_rresp;
  logic [CNT_W-1:0]    aw_pend, w_pend, aw_pend_n, w_pend_n, rd_n;
  logic [TW-1:0]       wcnt [7];
  logic [6:0]          wait_cond, tmo;
  logic [11:0]         viol, raw;
  logic [3:0]          new_code;
  logic aw_st, w_st, b_st, ar_st, r_st, aw_hs, w_hs, b_hs, ar_hs, r_hs, ovf;
  assign aw_st = p_awvalid & ~p_awready;
  assign w_st  = p_wvalid & ~p_wready;
  assign b_st  = p_bvalid & ~p_bready;
  assign ar_st = p_arvalid & ~p_arready;
  assign r_st  = p_rvalid & ~p_rready;
  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;
  assign b_hs  = bvalid & bready;
  assign ar_hs = arvalid & arready;
  assign r_hs  = rvalid & rready;
  assign wr_outstanding = aw_pend < w_pend ? aw_pend : w_pend;
  assign err_any = |err_status;
  // a simultaneous increment and decrement cancels, so it is never an overflow
  assign ovf = (aw_hs & ~b_hs & aw_pend == MAXC) | (w_hs & ~b_hs & w_pend == MAXC) |
               (ar_hs & ~r_hs & rd_outstanding == MAXC);
  assign aw_pend_n = (aw_hs && !b_hs && aw_pend != MAXC) ? aw_pend + 1'b1 :
                     (b_hs && !aw_hs && aw_pend != '0) ? aw_pend - 1'b1 : aw_pend;
  assign w_pend_n  = (w_hs && !b_hs && w_pend != MAXC) ? w_pend + 1'b1 :
                     (b_hs && !w_hs && w_pend != '0) ? w_pend - 1'b1 : w_pend;
  assign rd_n      = (ar_hs && !r_hs && rd_outstanding != MAXC) ? rd_outstanding + 1'b1 :
                     (r_hs && !ar_hs && rd_outstanding != '0) ? rd_outstanding - 1'b1 : rd_outstanding;
  assign wait_cond = {rd_outstanding != '0 && !rvalid, wr_outstanding != '0 && !bvalid,
                      rvalid & ~rready, arvalid & ~arready, bvalid & ~bready,
                      wvalid & ~wready, awvalid & ~awready};
  always_comb begin
    tmo = '0;
    for (int i = 0; i < 7; i++) tmo[i] = TIMEOUT != 0 && wait_cond[i] && wcnt[i] == TM1;
  end
  assign raw = {|tmo, ovf,
                rvalid & ~r_st & rd_outstanding == '0,
                bvalid & ~b_st & (aw_pend == '0 | w_pend == '0),
                r_st & (~rvalid | rdata != p_rdata | rresp != p_rresp),
                b_st & (~bvalid | bresp != p_bresp),
                ar_st & arvalid & (araddr != p_araddr | arprot != p_arprot),
                ar_st & ~arvalid,
                w_st & wvalid & (wdata != p_wdata | wstrb != p_wstrb),
                w_st & ~wvalid,
                aw_st & awvalid & (awaddr != p_awaddr | awprot != p_awprot),
                aw_st & ~awvalid};
  assign viol = hist_v ? raw : '0;
  always_comb begin
    new_code = '0;
    for (int i = 11; i >= 0; i--) if (viol[i]) new_code = 4'(i);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_v <= 1'b0;
      {p_awvalid, p_awready, p_wvalid, p_wready, p_bvalid, p_bready} <= '0;
      {p_arvalid, p_arready, p_rvalid, p_rready} <= '0;
      {p_awaddr, p_araddr, p_awprot, p_arprot} <= '0;
      {p_wdata, p_rdata, p_wstrb, p_bresp, p_rresp} <= '0;
      aw_pend <= '0;
      w_pend <= '0;
      rd_outstanding <= '0;
      for (int i = 0; i < 7; i++) wcnt[i] <= '0;
      err_status <= '0;
      err_pulse <= 1'b0;
      first_err_code <= '0;
    end else begin
      hist_v <= 1'b1;
      {p_awvalid, p_awready, p_wvalid, p_wready, p_bvalid, p_bready} <= {awvalid, awready, wvalid, wready, bvalid, bready};
      {p_arvalid, p_arready, p_rvalid, p_rready} <= {arvalid, arready, rvalid, rready};
      {p_awaddr, p_araddr, p_awprot, p_arprot} <= {awaddr, araddr, awprot, arprot};
      {p_wdata, p_rdata, p_wstrb, p_bresp, p_rresp} <= {wdata, rdata, wstrb, bresp, rresp};
      aw_pend <= aw_pend_n;
      w_pend <= w_pend_n;
      rd_outstanding <= rd_n;
      for (int i = 0; i < 7; i++)
        wcnt[i] <= (TIMEOUT == 0 || !wait_cond[i]) ? '0 : wcnt[i] == TMAX ? wcnt[i] : wcnt[i] + 1'b1;
      err_status <= (err_clr ? '0 : err_status) | viol;
      err_pulse <= |viol;
      first_err_code <= (|viol && (err_clr || err_status == '0)) ? new_code : err_clr ? '0 : first_err_code;
    end
  end
endmodule

// File: tb/tb_axi_lite_protocol_checker.sv
// tb_axi_lite_protocol_checker: directed scenarios against a TIMEOUT=8 checker and a TIMEOUT=0 twin
module tb_axi_lite_protocol_checker;
  logic clk = 0, rst_n = 0;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready, err_clr;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [2:0] awprot, arprot;
  logic [3:0] wstrb;
  logic [1:0] bresp, rresp;
  logic [11:0] err_status, err_status0;
  logic err_pulse, err_any, err_pulse0, err_any0;
  logic [3:0] first_err_code, first_err_code0;
  logic [2:0] wr_outstanding, rd_outstanding, wr_outstanding0, rd_outstanding0;
  int vec = 0, miss = 0;

  always #5 clk = ~clk;

  axi_lite_protocol_checker #(.ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .bvalid(bvalid), .bready(bready),
    .bresp(bresp), .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .err_clr(err_clr),
    .err_status(err_status), .err_pulse(err_pulse), .err_any(err_any), .first_err_code(first_err_code),
    .wr_outstanding(wr_outstanding), .rd_outstanding(rd_outstanding));

  axi_lite_protocol_checker #(.ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(4), .TIMEOUT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .bvalid(bvalid), .bready(bready),
    .bresp(bresp), .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .err_clr(err_clr),
    .err_status(err_status0), .err_pulse(err_pulse0), .err_any(err_any0), .first_err_code(first_err_code0),
    .wr_outstanding(wr_outstanding0), .rd_outstanding(rd_outstanding0));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    {awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready, err_clr} = '0;
    {awaddr, araddr, wdata, rdata} = '0;
    {awprot, arprot, wstrb, bresp, rresp} = '0;
  endtask

  task automatic do_reset(input string tag);
    idle();
    rst_n = 0;
    #1;
    vec++;
    if (err_status !== 12'h000 || err_pulse !== 1'b0 || err_any !== 1'b0 || first_err_code !== 4'd0 ||
        wr_outstanding !== 3'd0 || rd_outstanding !== 3'd0) begin
      miss++;
      $display("FAIL %s outputs during reset: status=%h pulse=%b any=%b code=%0d wr=%0d rd=%0d, want all 0",
               tag, err_status, err_pulse, err_any, first_err_code, wr_outstanding, rd_outstanding);
    end
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_reset();
    do_reset("reset");
    vec++;
    if (err_status !== 12'h000 || err_pulse !== 1'b0) begin
      miss++;
      $display("FAIL reset_release status=%h pulse=%b, want 000/0", err_status, err_pulse);
    end
  endtask

  task automatic test_valid_drop();
    awvalid = 1; awready = 0; awaddr = 32'h10;
    tick(); tick(); tick();
    vec++;
    if (err_status !== 12'h000) begin miss++; $display("FAIL aw_stall status=%h want 000", err_status); end
    awvalid = 0;
    tick();
    vec++;
    if (err_status !== 12'h001) begin miss++; $display("FAIL aw_drop status=%h want 001", err_status); end
    vec++;
    if (err_pulse !== 1'b1 || err_any !== 1'b1) begin
      miss++; $display("FAIL aw_drop pulse=%b any=%b want 1/1", err_pulse, err_any);
    end
    vec++;
    if (first_err_code !== 4'd0) begin miss++; $display("FAIL aw_drop code=%0d want 0", first_err_code); end
    tick();
    vec++;
    if (err_pulse !== 1'b0 || err_status !== 12'h001) begin
      miss++; $display("FAIL aw_drop_after pulse=%b status=%h want 0/001", err_pulse, err_status);
    end
  endtask

  task automatic test_err_clr();
    err_clr = 1;
    tick();
    err_clr = 0;
    vec++;
    if (err_status !== 12'h000 || err_any !== 1'b0 || first_err_code !== 4'd0) begin
      miss++; $display("FAIL clr status=%h any=%b code=%0d want 000/0/0", err_status, err_any, first_err_code);
    end
    awvalid = 1; awready = 0;
    tick();
    awvalid = 0; wvalid = 1; wready = 0; wdata = 32'hA5A5_A5A5; wstrb = 4'hF;
    tick();
    vec++;
    if (err_status !== 12'h001) begin miss++; $display("FAIL clr_pre status=%h want 001", err_status); end
    wdata = 32'h5A5A_5A5A; err_clr = 1;
    tick();
    err_clr = 0;
    vec++;
    if (err_status !== 12'h008 || first_err_code !== 4'd3 || err_pulse !== 1'b1) begin
      miss++; $display("FAIL clr_coincident status=%h code=%0d pulse=%b want 008/3/1", err_status, first_err_code, err_pulse);
    end
    wready = 1;
    tick();
    wvalid = 0; wready = 0;
    tick();
    vec++;
    if (err_status !== 12'h008 || err_pulse !== 1'b0) begin
      miss++; $display("FAIL w_complete status=%h pulse=%b want 008/0", err_status, err_pulse);
    end
  endtask

  task automatic test_simultaneous();
    do_reset("simul");
    arvalid = 1; arready = 0; araddr = 32'h100;
    tick();
    araddr = 32'h104; bvalid = 1; bready = 0;
    tick();
    vec++;
    if (err_status !== 12'h120 || first_err_code !== 4'd5 || err_pulse !== 1'b1) begin
      miss++; $display("FAIL simul status=%h code=%0d pulse=%b want 120/5/1", err_status, first_err_code, err_pulse);
    end
    tick();
    vec++;
    if (err_status !== 12'h120 || err_pulse !== 1'b0) begin
      miss++; $display("FAIL simul_hold status=%h pulse=%b want 120/0", err_status, err_pulse);
    end
  endtask

  task automatic test_outstanding();
    do_reset("outst");
    awvalid = 1; awready = 1; wvalid = 1; wready = 1;
    for (int i = 0; i < 4; i++) tick();
    vec++;
    if (wr_outstanding !== 3'd4 || err_status !== 12'h000) begin
      miss++; $display("FAIL fill wr=%0d status=%h want 4/000", wr_outstanding, err_status);
    end
    wvalid = 0; wready = 0;
    tick();
    vec++;
    if (err_status !== 12'h400 || wr_outstanding !== 3'd4 || first_err_code !== 4'd10) begin
      miss++; $display("FAIL overflow status=%h wr=%0d code=%0d want 400/4/10", err_status, wr_outstanding, first_err_code);
    end
    awvalid = 0; awready = 0; bvalid = 1; bready = 1;
    tick();
    vec++;
    if (wr_outstanding !== 3'd3) begin miss++; $display("FAIL drain1 wr=%0d want 3", wr_outstanding); end
    tick(); tick(); tick();
    bvalid = 0; bready = 0;
    vec++;
    if (wr_outstanding !== 3'd0 || err_status !== 12'h400 || err_pulse !== 1'b0) begin
      miss++; $display("FAIL drain wr=%0d status=%h pulse=%b want 0/400/0", wr_outstanding, err_status, err_pulse);
    end
  endtask

  task automatic test_timeout();
    int pulses;
    do_reset("tmo");
    arvalid = 1; arready = 1; araddr = 32'h200;
    tick();
    arvalid = 0; arready = 0;
    vec++;
    if (rd_outstanding !== 3'd1) begin miss++; $display("FAIL tmo_ar rd=%0d want 1", rd_outstanding); end
    for (int i = 1; i < 8; i++) tick();
    vec++;
    if (err_status !== 12'h000) begin miss++; $display("FAIL tmo_early status=%h want 000", err_status); end
    tick();
    vec++;
    if (err_status !== 12'h800 || err_pulse !== 1'b1 || first_err_code !== 4'd11) begin
      miss++; $display("FAIL tmo_fire status=%h pulse=%b code=%0d want 800/1/11", err_status, err_pulse, first_err_code);
    end
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      pulses += int'(err_pulse);
    end
    vec++;
    if (pulses !== 0) begin miss++; $display("FAIL tmo_once extra pulses=%0d want 0", pulses); end
    vec++;
    if (err_status0 !== 12'h000 || err_any0 !== 1'b0) begin
      miss++; $display("FAIL tmo_disabled status=%h any=%b want 000/0", err_status0, err_any0);
    end
    rvalid = 1; rready = 1;
    tick();
    rvalid = 0; rready = 0;
    vec++;
    if (rd_outstanding !== 3'd0 || err_status !== 12'h800 || err_pulse !== 1'b0) begin
      miss++; $display("FAIL tmo_r rd=%0d status=%h pulse=%b want 0/800/0", rd_outstanding, err_status, err_pulse);
    end
  endtask

  task automatic test_reset_mid();
    do_reset("mid_pre");
    bvalid = 1; bready = 1; arvalid = 1; arready = 1;
    tick();
    bvalid = 0; bready = 0;
    tick();
    arvalid = 0; arready = 0;
    vec++;
    if (rd_outstanding !== 3'd2 || err_status !== 12'h100 || first_err_code !== 4'd8) begin
      miss++; $display("FAIL mid_setup rd=%0d status=%h code=%0d want 2/100/8", rd_outstanding, err_status, first_err_code);
    end
    do_reset("mid");
    rvalid = 1; rready = 0; rdata = 32'hDEAD_BEEF;
    tick();
    vec++;
    if (err_status !== 12'h200 || first_err_code !== 4'd9 || err_pulse !== 1'b1) begin
      miss++; $display("FAIL r_orphan status=%h code=%0d pulse=%b want 200/9/1", err_status, first_err_code, err_pulse);
    end
    rready = 1;
    tick();
    rvalid = 0; rready = 0;
    vec++;
    if (err_status !== 12'h200 || err_pulse !== 1'b0 || rd_outstanding !== 3'd0) begin
      miss++; $display("FAIL r_continue status=%h pulse=%b rd=%0d want 200/0/0", err_status, err_pulse, rd_outstanding);
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_valid_drop();
    test_err_clr();
    test_simultaneous();
    test_outstanding();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
